// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding selects and the MIPS opcodes the hazard logic reasons about.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      LSTALL = 2'b01,
      JFLUSH = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_t;

   // Jump bubble counter only ever holds JUMP_PENALTY-1, and the penalty is at most 7
   localparam int JCNT_W = 3;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-stage inputs and hazard-control outputs.
// The pipeline side is the master, the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              ext_stall;
   logic              cnt_clr;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic              id_is_jump;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_regwrite;
   logic              ex_memread;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_regwrite;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_regwrite;

   logic              pc_en;
   logic              ifid_en;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              pipe_hold;
   logic              pc_redirect;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [1:0]        state_o;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output ext_stall, cnt_clr, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_is_jump, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
             mem_rd, mem_regwrite, wb_rd, wb_regwrite,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, pc_redirect,
             fwd_a, fwd_b, state_o, stall_cnt
   );

   modport slave (
      input  ext_stall, cnt_clr, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_is_jump, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
             mem_rd, mem_regwrite, wb_rd, wb_regwrite,
      output pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, pc_redirect,
             fwd_a, fwd_b, state_o, stall_cnt
   );

endinterface

// File: rtl/fwd_select.sv
// EX-stage forwarding select for one ALU operand.
// The younger MEM result wins over WB; register 0 is never forwarded.
module fwd_select
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_src,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_regwrite,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_regwrite,
   output fwd_t              o_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      o_sel = FWD_RF;
      if (w_mem_hit) begin
         o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
         o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stall, jump
// flush/redirect, EX forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int JUMP_PENALTY = 2,
   parameter int CNT_W        = 16
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   generate
      if (JUMP_PENALTY < 1 || JUMP_PENALTY > 7) begin : g_bad_penalty
         $error("pipe_hazard_ctrl: JUMP_PENALTY must be in 1..7");
      end
   endgenerate

   state_t             r_state;
   state_t             w_state_nxt;
   logic [JCNT_W-1:0]  r_jcnt;
   logic [JCNT_W-1:0]  w_jcnt_nxt;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic               w_lu;
   fwd_t               w_fwd_a;
   fwd_t               w_fwd_b;

   logic               w_pc_en;
   logic               w_ifid_en;
   logic               w_ifid_flush;
   logic               w_idex_bubble;
   logic               w_pipe_hold;
   logic               w_pc_redirect;

   fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
      .i_src          (bus.ex_rs),
      .i_mem_rd       (bus.mem_rd),
      .i_mem_regwrite (bus.mem_regwrite),
      .i_wb_rd        (bus.wb_rd),
      .i_wb_regwrite  (bus.wb_regwrite),
      .o_sel          (w_fwd_a)
   );

   fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
      .i_src          (bus.ex_rt),
      .i_mem_rd       (bus.mem_rd),
      .i_mem_regwrite (bus.mem_regwrite),
      .i_wb_rd        (bus.wb_rd),
      .i_wb_regwrite  (bus.wb_regwrite),
      .o_sel          (w_fwd_b)
   );

   // A load in EX whose destination the ID instruction actually reads
   assign w_lu = bus.ex_memread && bus.ex_regwrite && (bus.ex_rd != '0) && bus.id_valid &&
                 ((bus.id_uses_rs && (bus.ex_rd == bus.id_rs)) ||
                  (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset) begin
         r_state <= RUN;
         r_jcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_jcnt  <= w_jcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_jcnt_nxt    = r_jcnt;
      w_pc_en       = 1'b1;
      w_ifid_en     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_pipe_hold   = 1'b0;
      w_pc_redirect = 1'b0;

      if (bus.ext_stall) begin
         // Full freeze: state and jump counter hold, nothing moves
         w_pc_en     = 1'b0;
         w_ifid_en   = 1'b0;
         w_pipe_hold = 1'b1;
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_lu) begin
                  w_pc_en       = 1'b0;
                  w_ifid_en     = 1'b0;
                  w_idex_bubble = 1'b1;
                  w_state_nxt   = LSTALL;
               end else if (bus.id_valid && bus.id_is_jump) begin
                  w_ifid_flush = 1'b1;
                  if (JUMP_PENALTY == 1) begin
                     w_pc_redirect = 1'b1;
                  end else begin
                     w_pc_en     = 1'b0;
                     w_jcnt_nxt  = JCNT_W'(JUMP_PENALTY - 1);
                     w_state_nxt = JFLUSH;
                  end
               end
            end
            LSTALL: begin
               w_state_nxt = RUN;
            end
            JFLUSH: begin
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
               if (r_jcnt == '0) begin
                  w_pc_redirect = 1'b1;
                  w_state_nxt   = RUN;
               end else begin
                  w_pc_en    = 1'b0;
                  w_jcnt_nxt = r_jcnt - 1'b1;
               end
            end
            default: begin
               w_state_nxt = RUN;
            end
         endcase
      end

      // Outputs follow reset immediately, without waiting for a clock edge
      if (!reset) begin
         w_pc_en       = 1'b0;
         w_ifid_en     = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_pipe_hold   = 1'b0;
         w_pc_redirect = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (bus.cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.pc_en       = w_pc_en;
   assign bus.ifid_en     = w_ifid_en;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_bubble = w_idex_bubble;
   assign bus.pipe_hold   = w_pipe_hold;
   assign bus.pc_redirect = w_pc_redirect;
   assign bus.fwd_a       = reset ? w_fwd_a : FWD_RF;
   assign bus.fwd_b       = reset ? w_fwd_b : FWD_RF;
   assign bus.state_o     = r_state;
   assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a JUMP_PENALTY=2 unit under full test
// plus a JUMP_PENALTY=1 unit fed the same inputs for the immediate-redirect case.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
   pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus_j1 ();

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .JUMP_PENALTY(2), .CNT_W(CNT_W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .JUMP_PENALTY(1), .CNT_W(CNT_W)) u_dut_j1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_j1)
   );

   assign bus_j1.ext_stall    = bus.ext_stall;
   assign bus_j1.cnt_clr      = bus.cnt_clr;
   assign bus_j1.id_valid     = bus.id_valid;
   assign bus_j1.id_rs        = bus.id_rs;
   assign bus_j1.id_rt        = bus.id_rt;
   assign bus_j1.id_uses_rs   = bus.id_uses_rs;
   assign bus_j1.id_uses_rt   = bus.id_uses_rt;
   assign bus_j1.id_is_jump   = bus.id_is_jump;
   assign bus_j1.ex_rs        = bus.ex_rs;
   assign bus_j1.ex_rt        = bus.ex_rt;
   assign bus_j1.ex_rd        = bus.ex_rd;
   assign bus_j1.ex_regwrite  = bus.ex_regwrite;
   assign bus_j1.ex_memread   = bus.ex_memread;
   assign bus_j1.mem_rd       = bus.mem_rd;
   assign bus_j1.mem_regwrite = bus.mem_regwrite;
   assign bus_j1.wb_rd        = bus.wb_rd;
   assign bus_j1.wb_regwrite  = bus.wb_regwrite;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ext_stall    = 1'b0;
      bus.cnt_clr      = 1'b0;
      bus.id_valid     = 1'b0;
      bus.id_rs        = '0;
      bus.id_rt        = '0;
      bus.id_uses_rs   = 1'b0;
      bus.id_uses_rt   = 1'b0;
      bus.id_is_jump   = 1'b0;
      bus.ex_rs        = '0;
      bus.ex_rt        = '0;
      bus.ex_rd        = '0;
      bus.ex_regwrite  = 1'b0;
      bus.ex_memread   = 1'b0;
      bus.mem_rd       = '0;
      bus.mem_regwrite = 1'b0;
      bus.wb_rd        = '0;
      bus.wb_regwrite  = 1'b0;
   endtask

   task automatic load_in_ex(input logic [REG_AW-1:0] rd);
      bus.ex_memread  = 1'b1;
      bus.ex_regwrite = 1'b1;
      bus.ex_rd       = rd;
   endtask

   task automatic ex_bubble();
      bus.ex_memread  = 1'b0;
      bus.ex_regwrite = 1'b0;
      bus.ex_rd       = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state (a forwarding match is present) ----------------
      reset = 1'b0;
      clear_inputs();
      bus.mem_regwrite = 1'b1;
      bus.mem_rd       = 5'd2;
      bus.ex_rs        = 5'd2;
      @(negedge clk);
      check("rst_pc_en",       32'(bus.pc_en),       32'd0);
      check("rst_ifid_en",     32'(bus.ifid_en),     32'd0);
      check("rst_ifid_flush",  32'(bus.ifid_flush),  32'd1);
      check("rst_idex_bubble", 32'(bus.idex_bubble), 32'd1);
      check("rst_pipe_hold",   32'(bus.pipe_hold),   32'd0);
      check("rst_pc_redirect", 32'(bus.pc_redirect), 32'd0);
      check("rst_fwd_a",       32'(bus.fwd_a),       32'd0);
      check("rst_state",       32'(bus.state_o),     32'd0);
      check("rst_stall_cnt",   32'(bus.stall_cnt),   32'd0);
      #2;
      clear_inputs();
      reset = 1'b1;

      // ---------------- idle RUN ----------------
      tick();
      @(negedge clk);
      check("idle_pc_en",      32'(bus.pc_en),       32'd1);
      check("idle_ifid_en",    32'(bus.ifid_en),     32'd1);
      check("idle_flush",      32'(bus.ifid_flush),  32'd0);
      check("idle_bubble",     32'(bus.idex_bubble), 32'd0);
      check("idle_stall_cnt",  32'(bus.stall_cnt),   32'd0);

      // ---------------- forwarding ----------------
      tick();
      bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd2;
      bus.wb_regwrite  = 1'b1; bus.wb_rd  = 5'd2;
      bus.ex_rs = 5'd2; bus.ex_rt = 5'd3;
      #1;
      check("fwd_a_mem_prio",  32'(bus.fwd_a), 32'd1);
      check("fwd_b_nomatch",   32'(bus.fwd_b), 32'd0);
      bus.mem_regwrite = 1'b0;
      #1;
      check("fwd_a_wb",        32'(bus.fwd_a), 32'd2);
      bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.ex_rs = 5'd0;
      #1;
      check("fwd_a_r0",        32'(bus.fwd_a), 32'd0);
      bus.mem_rd = 5'd7; bus.ex_rt = 5'd7; bus.wb_rd = 5'd5; bus.ex_rs = 5'd5;
      #1;
      check("fwd_b_mem",       32'(bus.fwd_b), 32'd1);
      check("fwd_a_wb2",       32'(bus.fwd_a), 32'd2);
      clear_inputs();

      // ---------------- load-use qualifiers and ext_stall priority ----------------
      tick();
      load_in_ex(5'd0);
      bus.id_valid = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd0;
      #1;
      check("lu_r0_pc_en",     32'(bus.pc_en), 32'd1);
      bus.ex_rd = 5'd4; bus.id_rt = 5'd4; bus.id_uses_rt = 1'b0;
      #1;
      check("lu_unused_rt",    32'(bus.pc_en), 32'd1);
      bus.id_uses_rt = 1'b1;
      #1;
      check("lu_rt_pc_en",     32'(bus.pc_en),       32'd0);
      check("lu_rt_bubble",    32'(bus.idex_bubble), 32'd1);
      bus.ext_stall = 1'b1;
      #1;
      check("xs_over_lu_bubble", 32'(bus.idex_bubble), 32'd0);
      check("xs_over_lu_hold",   32'(bus.pipe_hold),   32'd1);
      check("xs_over_lu_pc_en",  32'(bus.pc_en),       32'd0);
      tick();                                   // frozen cycle counted: cnt 1
      bus.ext_stall = 1'b0;
      @(negedge clk);
      check("xs_held_state",   32'(bus.state_o),     32'd0);
      check("xs_cnt",          32'(bus.stall_cnt),   32'd1);
      check("lu_after_xs",     32'(bus.idex_bubble), 32'd1);
      tick();                                   // stall cycle counted: cnt 2
      ex_bubble();
      @(negedge clk);
      check("lstall_state",    32'(bus.state_o),   32'd1);
      check("lstall_pc_en",    32'(bus.pc_en),     32'd1);
      check("lstall_ifid_en",  32'(bus.ifid_en),   32'd1);
      check("lstall_cnt",      32'(bus.stall_cnt), 32'd2);
      tick();
      clear_inputs();

      // ---------------- lw R1 in EX, sub R?,R1 in ID ----------------
      tick();
      load_in_ex(5'd1);
      bus.id_valid = 1'b1; bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1;
      bus.id_rs = 5'd1; bus.id_rt = 5'd2;
      @(negedge clk);
      check("lw_pc_en",        32'(bus.pc_en),       32'd0);
      check("lw_bubble",       32'(bus.idex_bubble), 32'd1);
      check("lw_state",        32'(bus.state_o),     32'd0);
      tick();                                   // cnt 3
      ex_bubble();
      @(negedge clk);
      check("lw_next_state",   32'(bus.state_o),   32'd1);
      check("lw_next_pc_en",   32'(bus.pc_en),     32'd1);
      check("lw_next_cnt",     32'(bus.stall_cnt), 32'd3);
      tick();
      clear_inputs();
      @(negedge clk);
      check("lw_back_run",     32'(bus.state_o), 32'd0);

      // ---------------- jump, penalty 2 (and penalty 1 on u_dut_j1) ----------------
      tick();
      bus.id_valid = 1'b1; bus.id_is_jump = 1'b1;
      @(negedge clk);
      check("j_flush",         32'(bus.ifid_flush),    32'd1);
      check("j_pc_en",         32'(bus.pc_en),         32'd0);
      check("j_redirect",      32'(bus.pc_redirect),   32'd0);
      check("j1_redirect",     32'(bus_j1.pc_redirect), 32'd1);
      check("j1_pc_en",        32'(bus_j1.pc_en),       32'd1);
      check("j1_flush",        32'(bus_j1.ifid_flush),  32'd1);
      tick();                                   // cnt 4
      clear_inputs();
      @(negedge clk);
      check("j1_state_run",    32'(bus_j1.state_o),     32'd0);
      check("j1_no_redirect",  32'(bus_j1.pc_redirect), 32'd0);
      check("jf1_state",       32'(bus.state_o),     32'd2);
      check("jf1_flush",       32'(bus.ifid_flush),  32'd1);
      check("jf1_bubble",      32'(bus.idex_bubble), 32'd1);
      check("jf1_pc_en",       32'(bus.pc_en),       32'd0);
      check("jf1_redirect",    32'(bus.pc_redirect), 32'd0);
      check("jf1_cnt",         32'(bus.stall_cnt),   32'd4);
      tick();                                   // cnt 5
      @(negedge clk);
      check("jf2_flush",       32'(bus.ifid_flush),  32'd1);
      check("jf2_bubble",      32'(bus.idex_bubble), 32'd1);
      check("jf2_redirect",    32'(bus.pc_redirect), 32'd1);
      check("jf2_pc_en",       32'(bus.pc_en),       32'd1);
      check("jf2_cnt",         32'(bus.stall_cnt),   32'd5);
      tick();
      @(negedge clk);
      check("j_done_state",    32'(bus.state_o),     32'd0);
      check("j_done_redirect", 32'(bus.pc_redirect), 32'd0);
      check("j_done_cnt",      32'(bus.stall_cnt),   32'd5);

      // ---------------- ext_stall for 3 cycles during JFLUSH ----------------
      tick();
      bus.id_valid = 1'b1; bus.id_is_jump = 1'b1;
      tick();                                   // cnt 6, counter = 1
      clear_inputs();
      bus.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("xs_jf_state",    32'(bus.state_o),     32'd2);
         check("xs_jf_hold",     32'(bus.pipe_hold),   32'd1);
         check("xs_jf_redirect", 32'(bus.pc_redirect), 32'd0);
         check("xs_jf_cnt",      32'(bus.stall_cnt),   32'(6 + i));
         tick();
      end
      bus.ext_stall = 1'b0;                     // cnt 9
      @(negedge clk);
      check("xs_rel_bubble",   32'(bus.idex_bubble), 32'd1);
      check("xs_rel_redirect", 32'(bus.pc_redirect), 32'd0);
      check("xs_rel_hold",     32'(bus.pipe_hold),   32'd0);
      tick();                                   // cnt 10
      @(negedge clk);
      check("xs_end_redirect", 32'(bus.pc_redirect), 32'd1);
      check("xs_end_bubble",   32'(bus.idex_bubble), 32'd1);
      check("xs_end_cnt",      32'(bus.stall_cnt),   32'd10);
      tick();

      // ---------------- asynchronous reset mid-JFLUSH ----------------
      bus.id_valid = 1'b1; bus.id_is_jump = 1'b1;
      tick();                                   // cnt 11
      clear_inputs();
      @(negedge clk);
      check("ar_pre_state",    32'(bus.state_o), 32'd2);
      #1;
      reset = 1'b0;
      #1;
      check("ar_redirect",     32'(bus.pc_redirect), 32'd0);
      check("ar_state",        32'(bus.state_o),     32'd0);
      check("ar_cnt",          32'(bus.stall_cnt),   32'd0);
      check("ar_flush",        32'(bus.ifid_flush),  32'd1);
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("ar_after_redirect", 32'(bus.pc_redirect), 32'd0);
      check("ar_after_pc_en",    32'(bus.pc_en),       32'd1);
      tick();
      @(negedge clk);
      check("ar_late_redirect",  32'(bus.pc_redirect), 32'd0);
      check("ar_late_cnt",       32'(bus.stall_cnt),   32'd0);

      // ---------------- counter saturation and clear ----------------
      tick();
      bus.ext_stall = 1'b1;
      repeat (14) @(posedge clk);
      @(negedge clk);
      check("sat_14",          32'(bus.stall_cnt), 32'd14);
      @(posedge clk);
      @(negedge clk);
      check("sat_15",          32'(bus.stall_cnt), 32'd15);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("sat_hold",        32'(bus.stall_cnt), 32'd15);
      bus.cnt_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("clr_wins",        32'(bus.stall_cnt), 32'd0);
      bus.cnt_clr   = 1'b0;
      bus.ext_stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("clr_stays",       32'(bus.stall_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard controller for the 5-stage MIPS pipeline. It replaces the ad-hoc stall, PC-hold and forwarding logic with one block. It generates PC/IF-ID enables, IF-ID flush, ID-EX bubble, EX-stage forwarding selects, a jump-redirect pulse and a saturating stall counter. It sits beside the pipeline registers and takes the register indices and control bits of the ID, EX, MEM and WB stages.

Parameters:
REG_AW, 5, register index width
JUMP_PENALTY, 2, bubble cycles inserted after a jump is decoded in ID (legal 1..7)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
ext_stall  in  1  external freeze request (e.g. memory not ready)
cnt_clr  in  1  synchronous clear of stall counter
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register rs
id_rt  in  REG_AW  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_jump  in  1  ID instruction is J
ex_rs  in  REG_AW  EX stage rs (forwarding compare)
ex_rt  in  REG_AW  EX stage rt (forwarding compare)
ex_rd  in  REG_AW  EX stage destination (post RegDst mux)
ex_regwrite  in  1  EX writes a register
ex_memread  in  1  EX is a load
mem_rd  in  REG_AW  MEM stage destination
mem_regwrite  in  1  MEM writes a register
wb_rd  in  REG_AW  WB stage destination
wb_regwrite  in  1  WB writes a register
pc_en  out  1  PC register load enable
ifid_en  out  1  IF-ID register load enable
ifid_flush  out  1  IF-ID loads a NOP
idex_bubble  out  1  ID-EX loads zeroed control
pipe_hold  out  1  EX-MEM and MEM-WB hold
pc_redirect  out  1  PC mux selects the jump target this cycle
fwd_a  out  2  ALU operand A select: 00 regfile, 01 MEM result, 10 WB result
fwd_b  out  2  ALU operand B select, same encoding
state_o  out  2  current FSM state
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset is asserted asynchronously:
  - State goes to RUN; jump counter is 0; stall_cnt is 0.
  - Outputs while reset is low: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, pc_redirect=0, fwd_a=fwd_b=00.
- Forwarding is combinational and always valid:
  - fwd_a=01 if mem_regwrite, mem_rd!=0 and mem_rd==ex_rs.
  - Otherwise fwd_a=10 if wb_regwrite, wb_rd!=0 and wb_rd==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b is identical, using ex_rt.
  - MEM has priority over WB. Register 0 is never forwarded.
- Load-use hazard: lu = ex_memread & ex_regwrite & ex_rd!=0 & id_valid & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- FSM states: RUN=00, LSTALL=01, JFLUSH=10. A state is held whenever ext_stall=1.
- RUN:
  - ext_stall=1: pc_en=0, ifid_en=0, pipe_hold=1, idex_bubble=0 (full freeze).
  - lu=1: pc_en=0, ifid_en=0, idex_bubble=1; next state LSTALL.
  - id_valid & id_is_jump & !lu: ifid_flush=1, pc_en=0; load jump counter with JUMP_PENALTY-1; next state JFLUSH. If JUMP_PENALTY=1, do not enter JFLUSH: assert pc_redirect=1, pc_en=1 and stay in RUN.
  - Otherwise: pc_en=1, ifid_en=1, all flush/bubble outputs 0.
- LSTALL: lasts exactly one cycle with normal enables (pc_en=1, ifid_en=1), then returns to RUN. A second load-use hazard is re-evaluated in RUN.
- JFLUSH:
  - Every cycle: ifid_flush=1, idex_bubble=1, pc_en=0, and the counter decrements.
  - When the counter reaches 0: pc_redirect=1, pc_en=1, return to RUN.
  - Total bubbles after the jump = JUMP_PENALTY.
- Priority: ext_stall > lu > jump. A jump in ID blocked by lu is recognised after the stall releases.
- stall_cnt:
  - Increments when pc_en=0 and reset is high.
  - Saturates at all-ones.
  - cnt_clr wins over increment (count becomes 0 that cycle).
- Reset asserted mid-JFLUSH or mid-LSTALL aborts immediately. No pc_redirect is issued afterwards.
- Elaboration error if JUMP_PENALTY is outside 1..7.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encodings RUN/LSTALL/JFLUSH.
  - Forwarding select constants FWD_RF/FWD_MEM/FWD_WB.
  - MIPS opcode constants (LW, SW, SUB-R, XORI, J).
- One sub-module, fwd_select, instantiated twice (operand A and B). It contains the combinational priority compare for a single operand.

Test Plan:
- lw R1 in EX (ex_memread=1, ex_rd=1), sub in ID with id_rs=1 -> one cycle: pc_en=0, idex_bubble=1, state_o=01; next cycle pc_en=1; stall_cnt=1.
- J in ID with JUMP_PENALTY=2 -> two cycles with ifid_flush=1 and idex_bubble=1; pc_redirect=1 only in the 2nd cycle; stall_cnt increments by 2 (first cycle pc_en=0, plus the JFLUSH cycle).
- mem_rd=2 and wb_rd=2, both regwrite, ex_rs=2 -> fwd_a=01. With mem_regwrite=0 -> fwd_a=10. With ex_rs=0 and matching rd=0 -> fwd_a=00.
- ext_stall=1 for 3 cycles during JFLUSH -> state_o stays 10, counter frozen, pipe_hold=1; remaining bubbles complete after release.
- reset low asynchronously mid-JFLUSH -> pc_redirect=0, state_o=00, stall_cnt=0 without waiting for a clock edge.
- Force 2^CNT_W+5 stall cycles (CNT_W=4 build) -> stall_cnt holds 15. cnt_clr pulse -> 0.
